// File: rtl/dpc_lut_builder_if.sv
// Pixel AXI-Stream bundle feeding the dead-pixel LUT builder.
// The master drives the pixel beat; the slave returns tready.
interface dpc_lut_builder_if #(
  parameter int WIDTH = 8
);
  logic             s_axis_tvalid;
  logic             s_axis_tready;
  logic [WIDTH-1:0] s_axis_tdata;
  logic             s_axis_tuser;
  logic             s_axis_tlast;

  modport master (
    output s_axis_tvalid,
    output s_axis_tdata,
    output s_axis_tuser,
    output s_axis_tlast,
    input  s_axis_tready
  );

  modport slave (
    input  s_axis_tvalid,
    input  s_axis_tdata,
    input  s_axis_tuser,
    input  s_axis_tlast,
    output s_axis_tready
  );
endinterface

// File: rtl/dpc_lut_builder.sv
// Dead-pixel LUT builder: taps one armed frame, classifies pixels
// against dark/bright thresholds and writes bad {row,col} in raster order.
module dpc_lut_builder #(
  parameter int WIDTH          = 8,
  parameter int ROW            = 6,
  parameter int COL            = 8,
  parameter int CNT_WIDTH      = 10,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int MAX_POINTS     = 128
) (
  input  logic                      clk,
  input  logic                      reset,
  dpc_lut_builder_if.slave          s_axis,
  input  logic                      go,
  input  logic [WIDTH-1:0]          thr_low,
  input  logic [WIDTH-1:0]          thr_high,
  output logic                      wen_lut,
  output logic [AXI_ADDR_WIDTH-1:0] waddr_lut,
  output logic [AXI_DATA_WIDTH-1:0] wdata_lut,
  output logic [7:0]                bad_point_num,
  output logic                      busy,
  output logic                      done,
  output logic                      overflow,
  output logic                      frame_err
);

  if (AXI_DATA_WIDTH < 2 * CNT_WIDTH || COL > (1 << CNT_WIDTH) ||
      ROW > (1 << CNT_WIDTH) || MAX_POINTS > 255) begin : g_param_chk
    $error("dpc_lut_builder: parameter combination does not fit");
  end

  typedef enum logic [1:0] {IDLE, ARM, SCAN, DONE} state_e;

  localparam logic [7:0] MAXP = 8'(MAX_POINTS);
  localparam logic [CNT_WIDTH-1:0] LAST_ROW = CNT_WIDTH'(ROW - 1);

  state_e                    state_q;
  logic                      go_a_q, go_b_q;
  logic [CNT_WIDTH-1:0]      row_q, col_q;
  logic [CNT_WIDTH-1:0]      row_d, col_d;
  logic [CNT_WIDTH-1:0]      cur_row, cur_col;
  logic                      wen_q;
  logic [AXI_ADDR_WIDTH-1:0] waddr_q;
  logic [AXI_DATA_WIDTH-1:0] wdata_q;
  logic [7:0]                bpn_q;
  logic                      busy_q, done_q, ovf_q, ferr_q;
  logic                      fire, go_rise, classify, bad;
  logic                      wr_en, sat_hit, last_px, sof;

  assign s_axis.s_axis_tready = ~reset;

  assign fire    = s_axis.s_axis_tvalid & s_axis.s_axis_tready;
  assign sof     = fire & s_axis.s_axis_tuser;
  assign go_rise = go_a_q & ~go_b_q;

  // A start-of-frame beat is pixel (0,0) regardless of counter state
  always_comb begin
    cur_row  = s_axis.s_axis_tuser ? '0 : row_q;
    cur_col  = s_axis.s_axis_tuser ? '0 : col_q;
    row_d    = cur_row;
    col_d    = cur_col + 1'b1;
    if (s_axis.s_axis_tlast) begin
      row_d = cur_row + 1'b1;
      col_d = '0;
    end
    classify = fire & (((state_q == ARM) & s_axis.s_axis_tuser) |
                       ((state_q == SCAN) & ~s_axis.s_axis_tuser));
    bad      = classify & ((s_axis.s_axis_tdata <= thr_low) |
                           (s_axis.s_axis_tdata >= thr_high));
    wr_en    = bad & (bpn_q != MAXP);
    sat_hit  = bad & (bpn_q == MAXP);
    last_px  = fire & s_axis.s_axis_tlast & (cur_row == LAST_ROW);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      go_a_q  <= 1'b0;
      go_b_q  <= 1'b0;
      row_q   <= '0;
      col_q   <= '0;
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      bpn_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      go_a_q <= go;
      go_b_q <= go_a_q;
      if (fire) begin
        row_q <= row_d;
        col_q <= col_d;
      end
      wen_q <= wr_en;
      if (wr_en) begin
        waddr_q <= AXI_ADDR_WIDTH'(bpn_q);
        wdata_q <= AXI_DATA_WIDTH'({cur_row, cur_col});
        bpn_q   <= bpn_q + 1'b1;
      end
      if (sat_hit) ovf_q <= 1'b1;
      unique case (state_q)
        IDLE, DONE: begin
          if (go_rise) begin
            state_q <= ARM;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            bpn_q   <= '0;
            ovf_q   <= 1'b0;
            ferr_q  <= 1'b0;
          end
        end
        ARM: begin
          if (sof) state_q <= SCAN;
        end
        SCAN: begin
          if (sof || last_px) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
          if (sof) ferr_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wen_lut       = wen_q;
  assign waddr_lut     = waddr_q;
  assign wdata_lut     = wdata_q;
  assign bad_point_num = bpn_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign overflow      = ovf_q;
  assign frame_err     = ferr_q;

endmodule

// File: tb/tb_dpc_lut_builder.sv
// Bench for dpc_lut_builder: default depth and a 4-entry instance
// share one pixel stream and are checked against a frame-level model.
module tb_dpc_lut_builder;
  localparam int R = 6;
  localparam int C = 8;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] c;
  } wr_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       go = 1'b0;
  logic [7:0] thr_low = 8'd0;
  logic [7:0] thr_high = 8'hff;

  always #5 clk = ~clk;

  dpc_lut_builder_if #(.WIDTH(8)) ax0 ();
  dpc_lut_builder_if #(.WIDTH(8)) ax1 ();

  assign ax1.s_axis_tvalid = ax0.s_axis_tvalid;
  assign ax1.s_axis_tdata  = ax0.s_axis_tdata;
  assign ax1.s_axis_tuser  = ax0.s_axis_tuser;
  assign ax1.s_axis_tlast  = ax0.s_axis_tlast;

  logic        wen0, wen1;
  logic [31:0] waddr0, waddr1, wdata0, wdata1;
  logic [7:0]  bpn0, bpn1;
  logic        busy0, busy1, done0, done1;
  logic        ovf0, ovf1, ferr0, ferr1;

  dpc_lut_builder dut (
    .clk(clk), .reset(reset), .s_axis(ax0), .go(go),
    .thr_low(thr_low), .thr_high(thr_high),
    .wen_lut(wen0), .waddr_lut(waddr0), .wdata_lut(wdata0),
    .bad_point_num(bpn0), .busy(busy0), .done(done0),
    .overflow(ovf0), .frame_err(ferr0)
  );

  dpc_lut_builder #(.MAX_POINTS(4)) dut4 (
    .clk(clk), .reset(reset), .s_axis(ax1), .go(go),
    .thr_low(thr_low), .thr_high(thr_high),
    .wen_lut(wen1), .waddr_lut(waddr1), .wdata_lut(wdata1),
    .bad_point_num(bpn1), .busy(busy1), .done(done1),
    .overflow(ovf1), .frame_err(ferr1)
  );

  int cyc = 0;
  always @(posedge clk) cyc++;

  wr_t q0[$];
  wr_t q1[$];
  always @(negedge clk) begin
    if (wen0) q0.push_back({waddr0, wdata0, 32'(cyc)});
    if (wen1) q1.push_back({waddr1, wdata1, 32'(cyc)});
  end

  int nvec = 0;
  int nerr = 0;
  logic [7:0]  pix [R][C];
  logic [31:0] expq[$];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic px(input logic [7:0] d, input bit u, input bit l,
                    input bit gaps);
    if (gaps) begin
      while ($urandom_range(0, 3) == 0) begin
        ax0.s_axis_tvalid = 1'b0;
        ax0.s_axis_tdata  = 8'($urandom);
        tick();
      end
    end
    ax0.s_axis_tvalid = 1'b1;
    ax0.s_axis_tdata  = d;
    ax0.s_axis_tuser  = u;
    ax0.s_axis_tlast  = l;
    tick();
    ax0.s_axis_tvalid = 1'b0;
    ax0.s_axis_tuser  = 1'b0;
    ax0.s_axis_tlast  = 1'b0;
  endtask

  task automatic send_rows(input int r0, input int r1, input bit gaps);
    for (int r = r0; r <= r1; r++)
      for (int c = 0; c < C; c++)
        px(pix[r][c], (r == 0 && c == 0), (c == C - 1), gaps);
  endtask

  task automatic fill(input logic [7:0] v);
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        pix[r][c] = v;
  endtask

  task automatic rand_frame();
    thr_low  = 8'($urandom_range(0, 60));
    thr_high = 8'($urandom_range(190, 255));
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        case ($urandom_range(0, 5))
          0: pix[r][c] = thr_low;
          1: pix[r][c] = thr_low + 8'd1;
          2: pix[r][c] = thr_high;
          3: pix[r][c] = thr_high - 8'd1;
          default: pix[r][c] = 8'($urandom);
        endcase
  endtask

  // Reference: bad pixels of the classified rows, in raster order
  task automatic build_exp(input int nrows);
    expq.delete();
    for (int r = 0; r < nrows; r++)
      for (int c = 0; c < C; c++)
        if (pix[r][c] <= thr_low || pix[r][c] >= thr_high)
          expq.push_back({12'd0, 10'(r), 10'(c)});
  endtask

  task automatic arm();
    go = 1'b0;
    repeat (3) tick();
    q0.delete();
    q1.delete();
    go = 1'b1;
    repeat (4) tick();
  endtask

  task automatic check_dut(input string tag, input wr_t q[$],
                           input int maxp, input logic [7:0] bpn,
                           input logic ovf, input logic dn,
                           input logic bsy, input logic fe,
                           input bit fe_exp);
    int n;
    int nw;
    n  = expq.size();
    nw = (n > maxp) ? maxp : n;
    chk({tag, ".nwr"}, 64'(q.size()), 64'(nw));
    for (int i = 0; i < nw && i < q.size(); i++) begin
      chk({tag, ".addr"}, 64'(q[i].a), 64'(i));
      chk({tag, ".data"}, 64'(q[i].d), 64'(expq[i]));
    end
    chk({tag, ".bpn"}, 64'(bpn), 64'(nw));
    chk({tag, ".ovf"}, 64'(ovf), 64'(n > maxp));
    chk({tag, ".done"}, 64'(dn), 64'd1);
    chk({tag, ".busy"}, 64'(bsy), 64'd0);
    chk({tag, ".ferr"}, 64'(fe), 64'(fe_exp));
  endtask

  task automatic check_both(input string tag, input bit fe_exp);
    check_dut({tag, ".d128"}, q0, 128, bpn0, ovf0, done0, busy0, ferr0,
              fe_exp);
    check_dut({tag, ".d4"}, q1, 4, bpn1, ovf1, done1, busy1, ferr1,
              fe_exp);
  endtask

  initial begin
    ax0.s_axis_tvalid = 1'b0;
    ax0.s_axis_tdata  = 8'd0;
    ax0.s_axis_tuser  = 1'b0;
    ax0.s_axis_tlast  = 1'b0;

    // reset state
    repeat (2) tick();
    chk("rst.tready", 64'(ax0.s_axis_tready), 64'd0);
    chk("rst.wen", 64'(wen0), 64'd0);
    chk("rst.waddr", 64'(waddr0), 64'd0);
    chk("rst.wdata", 64'(wdata0), 64'd0);
    chk("rst.bpn", 64'(bpn0), 64'd0);
    chk("rst.flags", 64'({busy0, done0, ovf0, ferr0}), 64'd0);
    reset = 1'b0;
    tick();
    chk("rst.tready_up", 64'(ax0.s_axis_tready), 64'd1);

    // idle stream, never armed
    thr_low  = 8'd5;
    thr_high = 8'd250;
    fill(8'd0);
    send_rows(0, R - 1, 1'b1);
    repeat (3) tick();
    chk("idle.nwr", 64'(q0.size()), 64'd0);
    chk("idle.done", 64'(done0), 64'd0);
    chk("idle.bpn", 64'(bpn0), 64'd0);

    // two isolated bad pixels
    fill(8'd128);
    pix[2][3] = 8'd0;
    pix[4][7] = 8'd255;
    build_exp(R);
    arm();
    send_rows(0, R - 1, 1'b1);
    repeat (3) tick();
    check_both("two", 1'b0);

    // adjacent bad pixels, continuous tvalid
    fill(8'd128);
    pix[1][0] = 8'd5;
    pix[1][1] = 8'd250;
    build_exp(R);
    arm();
    send_rows(0, R - 1, 1'b0);
    repeat (3) tick();
    check_both("adj", 1'b0);
    if (q0.size() >= 2)
      chk("adj.b2b", 64'(q0[1].c - q0[0].c), 64'd1);

    // six bad pixels, 4-entry instance saturates
    fill(8'd100);
    pix[0][0] = 8'd0;
    pix[0][7] = 8'd255;
    pix[2][2] = 8'd3;
    pix[3][5] = 8'd251;
    pix[5][0] = 8'd1;
    pix[5][7] = 8'd254;
    build_exp(R);
    arm();
    send_rows(0, R - 1, 1'b1);
    repeat (3) tick();
    check_both("sat", 1'b0);

    // early start-of-frame at row 3
    fill(8'd100);
    pix[0][1] = 8'd0;
    pix[2][7] = 8'd255;
    pix[3][2] = 8'd0;
    build_exp(3);
    arm();
    send_rows(0, 2, 1'b1);
    fill(8'd0);
    send_rows(0, R - 1, 1'b1);
    repeat (3) tick();
    check_both("early", 1'b1);

    // reset in the middle of a scan
    fill(8'd100);
    pix[0][2] = 8'd0;
    pix[1][4] = 8'd0;
    arm();
    send_rows(0, 1, 1'b0);
    go = 1'b0;
    reset = 1'b1;
    ax0.s_axis_tvalid = 1'b1;
    ax0.s_axis_tdata  = 8'd0;
    q0.delete();
    q1.delete();
    repeat (2) tick();
    chk("mrst.tready", 64'(ax0.s_axis_tready), 64'd0);
    reset = 1'b0;
    ax0.s_axis_tvalid = 1'b0;
    repeat (3) tick();
    chk("mrst.nwr", 64'(q0.size()), 64'd0);
    chk("mrst.bpn", 64'(bpn0), 64'd0);
    chk("mrst.flags", 64'({busy0, done0, ovf0, ferr0}), 64'd0);
    fill(8'd100);
    pix[5][7] = 8'd255;
    build_exp(R);
    arm();
    send_rows(0, R - 1, 1'b1);
    repeat (3) tick();
    check_both("mrst2", 1'b0);

    // randomized frames
    for (int k = 0; k < 6; k++) begin
      rand_frame();
      build_exp(R);
      arm();
      send_rows(0, R - 1, 1'b1);
      repeat (3) tick();
      check_both($sformatf("rnd%0d", k), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
